// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next PC and the PC-IF register's Flush1/Stall1 controls.
// Latency: PC, Flush1, running and fetch_count change one edge after the event that causes them. Stall1 is combinational.
// Backpressure: when hazard_stall=1 or mem_ready=0 in RUN, the PC holds and Stall1 is raised. A redirect overrides the stall.
module pc_sequencer #(
    parameter int          PC_W     = 9,
    parameter int unsigned RESET_PC = 0,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             hazard_stall,
    input  logic             mem_ready,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             halt_req,
    output logic [PC_W-1:0]  PC,
    output logic             Flush1,
    output logic             Stall1,
    output logic             running,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [PC_W-1:0] W_RESET_PC = RESET_PC[PC_W-1:0];

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_REDIRECT = 2'd2,
        S_HALTED   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_nxt;
    logic             r_flush;
    logic             w_flush_nxt;
    logic             r_running;
    logic             w_running_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_advance;
    logic             w_cnt_sat;
    logic             w_stall;

    assign w_advance = !hazard_stall && mem_ready;
    assign w_cnt_sat = &r_cnt;

    // Next-state, next-PC, flush and stall decision; redirect outranks halt, which outranks stall.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_flush_nxt = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_pc_nxt = W_RESET_PC;
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_stall = !w_advance;
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_flush_nxt = 1'b1;
                    w_state_nxt = S_REDIRECT;
                end else if (halt_req) begin
                    w_state_nxt = S_HALTED;
                end else if (w_advance) begin
                    w_pc_nxt = r_pc + 1'b1;
                    if (!w_cnt_sat) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_REDIRECT: begin
                // The flush makes the PC-IF register load the target whether or not a stall is present.
                w_stall = 1'b0;
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_flush_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_HALTED: begin
                if (redirect_valid) begin
                    w_pc_nxt    = redirect_pc;
                    w_flush_nxt = 1'b1;
                    w_state_nxt = S_REDIRECT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_pc_nxt    = W_RESET_PC;
            end
        endcase
        w_running_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_REDIRECT);
    end

    // State and registered outputs; reset clears everything at once, including in-flight redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= W_RESET_PC;
            r_flush   <= 1'b0;
            r_running <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_flush   <= w_flush_nxt;
            r_running <= w_running_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign PC          = r_pc;
    assign Flush1      = r_flush;
    assign Stall1      = w_stall;
    assign running     = r_running;
    assign fetch_count = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int PC_W  = 9;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             hazard_stall;
    logic             mem_ready;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             halt_req;
    logic [PC_W-1:0]  PC;
    logic             Flush1;
    logic             Stall1;
    logic             running;
    logic [CNT_W-1:0] fetch_count;

    pc_sequencer #(.PC_W(PC_W), .RESET_PC(0), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .hazard_stall   (hazard_stall),
        .mem_ready      (mem_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .PC             (PC),
        .Flush1         (Flush1),
        .Stall1         (Stall1),
        .running        (running),
        .fetch_count    (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int pc;
        bit fl;
        bit st;
        bit rn;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the sequencer is described by three flags.
    // active = fetching or redirecting, flushing = redirect being delivered, halted = stopped by HALT.
    int m_pc;
    bit m_active;
    bit m_flushing;
    bit m_halted;
    int m_cnt;

    task automatic model_reset();
        m_pc       = 0;
        m_active   = 0;
        m_flushing = 0;
        m_halted   = 0;
        m_cnt      = 0;
    endtask

    task automatic model_edge(input bit st, hz, mr, rv, input int rpc, input bit hr);
        bit adv;
        adv = !hz && mr;
        if (m_halted) begin
            if (rv) begin
                m_pc = rpc; m_flushing = 1; m_active = 1; m_halted = 0;
            end
        end else if (!m_active) begin
            if (st) m_active = 1;
        end else if (m_flushing) begin
            if (rv) m_pc = rpc;
            else    m_flushing = 0;
        end else begin
            if (rv) begin
                m_pc = rpc; m_flushing = 1;
            end else if (hr) begin
                m_halted = 1; m_active = 0;
            end else if (adv) begin
                m_pc = (m_pc + 1) % (1 << PC_W);
                if (m_cnt < (1 << CNT_W) - 1) m_cnt = m_cnt + 1;
            end
        end
    endtask

    // One clock of stimulus: drive inputs, queue what the DUT must show before the next edge, then advance the model.
    task automatic step(input bit rst, st, hz, mr, rv, input int rpc, input bit hr);
        exp_t e;
        rst_n          = !rst;
        start          = st;
        hazard_stall   = hz;
        mem_ready      = mr;
        redirect_valid = rv;
        redirect_pc    = rv ? rpc[PC_W-1:0] : PC_W'($urandom);
        halt_req       = hr;
        if (rst) model_reset();
        e.pc  = m_pc;
        e.fl  = m_flushing;
        e.rn  = m_active;
        e.cnt = m_cnt;
        if (m_halted || !m_active) e.st = 1;
        else if (m_flushing)       e.st = 0;
        else                       e.st = !(!hz && mr);
        q.push_back(e);
        @(posedge clk);
        if (!rst) model_edge(st, hz, mr, rv, rpc, hr);
        #1;
    endtask

    // Monitor: the DUT presents a fresh set of outputs every cycle; compare on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks = checks + 5;
            if (int'(PC) != e.pc) begin
                errors = errors + 1;
                $display("FAIL pc t=%0t got=%0h exp=%0h", $time, PC, e.pc);
            end
            if (Flush1 !== e.fl) begin
                errors = errors + 1;
                $display("FAIL flush1 t=%0t got=%b exp=%b", $time, Flush1, e.fl);
            end
            if (Stall1 !== e.st) begin
                errors = errors + 1;
                $display("FAIL stall1 t=%0t got=%b exp=%b", $time, Stall1, e.st);
            end
            if (running !== e.rn) begin
                errors = errors + 1;
                $display("FAIL running t=%0t got=%b exp=%b", $time, running, e.rn);
            end
            if (int'(fetch_count) != e.cnt || $isunknown(fetch_count)) begin
                errors = errors + 1;
                $display("FAIL fetch_count t=%0t got=%0d exp=%0d", $time, fetch_count, e.cnt);
            end
        end
    end

    initial begin
        model_reset();
        rst_n = 1'b0; start = 0; hazard_stall = 0; mem_ready = 1;
        redirect_valid = 0; redirect_pc = '0; halt_req = 0;
        @(posedge clk);
        #1;
        // reset state
        step(1, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        // start then straight-line fetching
        step(0, 1, 0, 1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 1, 0, 0, 0);
        // park at 0x10, then stalls from hazard and from memory
        step(0, 0, 0, 1, 1, 'h10, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 1, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        // redirect to 0x1A while a hazard stall is present
        step(0, 0, 0, 1, 1, 'h05, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 1, 'h1A, 0);
        repeat (3) step(0, 0, 0, 1, 0, 0, 0);
        // back-to-back redirects, halt in the same cycle ignored
        step(0, 0, 0, 1, 1, 'h40, 0);
        step(0, 0, 0, 1, 1, 'h80, 1);
        repeat (2) step(0, 0, 0, 1, 0, 0, 0);
        // wrap at the top, halt, ignored start, exit via redirect
        step(0, 0, 0, 1, 1, 'h1FF, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 1);
        repeat (2) step(0, 1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 'h020, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        // fetch counter saturation
        repeat (20) step(0, 0, 0, 1, 0, 0, 0);
        // asynchronous reset in the middle of a redirect
        step(0, 0, 0, 1, 1, 'h0AA, 0);
        step(1, 0, 0, 1, 1, 'h0BB, 0);
        step(1, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0);
        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 79) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 511)),
                 $urandom_range(0, 19) == 0);
        end
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
